// File: rtl/cpu_fpu_pkg.sv
// Shared definitions for the FPU dispatcher: op codes, canonical NaN and FSM states.
package cpu_fpu_pkg;

  localparam logic [3:0] FOP_FADD   = 4'd0;
  localparam logic [3:0] FOP_FSUB   = 4'd1;
  localparam logic [3:0] FOP_FMIN   = 4'd2;
  localparam logic [3:0] FOP_FMAX   = 4'd3;
  localparam logic [3:0] FOP_FSGNJ  = 4'd4;
  localparam logic [3:0] FOP_FSGNJN = 4'd5;
  localparam logic [3:0] FOP_FSGNJX = 4'd6;
  localparam logic [3:0] FOP_FEQ    = 4'd7;
  localparam logic [3:0] FOP_FLT    = 4'd8;
  localparam logic [3:0] FOP_FLE    = 4'd9;

  localparam logic [31:0] QNAN = 32'h7FC00000;

  typedef enum logic [2:0] {
    ST_IDLE    = 3'd0,
    ST_LOCAL   = 3'd1,
    ST_ISSUE   = 3'd2,
    ST_RELEASE = 3'd3,
    ST_DONE    = 3'd4
  } state_e;

  function automatic logic isAddOp(input logic [3:0] op);
    return (op == FOP_FADD) || (op == FOP_FSUB);
  endfunction

endpackage

// File: rtl/cpu_fpu_compare.sv
// Combinational binary32 comparator: NaN detection, IEEE eq/lt, and a total
// order (-0 below +0) that min/max rely on.
module cpu_fpu_compare (
  input  logic [31:0] a_i,
  input  logic [31:0] b_i,
  output logic        is_nan_a_o,
  output logic        is_nan_b_o,
  output logic        eq_o,
  output logic        lt_o,
  output logic        lt_total_o
);

  logic        signA;
  logic        signB;
  logic [30:0] magA;
  logic [30:0] magB;
  logic        anyNan;
  logic        bothZero;

  assign signA    = a_i[31];
  assign signB    = b_i[31];
  assign magA     = a_i[30:0];
  assign magB     = b_i[30:0];

  assign is_nan_a_o = (a_i[30:23] == 8'hFF) && (a_i[22:0] != 23'd0);
  assign is_nan_b_o = (b_i[30:23] == 8'hFF) && (b_i[22:0] != 23'd0);
  assign anyNan     = is_nan_a_o || is_nan_b_o;
  assign bothZero   = (magA == 31'd0) && (magB == 31'd0);

  // Sign-magnitude ordering: negative magnitudes sort in reverse.
  always_comb begin
    lt_total_o = 1'b0;
    if (signA != signB) begin
      lt_total_o = signA;
    end else if (!signA) begin
      lt_total_o = magA < magB;
    end else begin
      lt_total_o = magA > magB;
    end
  end

  assign eq_o = !anyNan && ((a_i == b_i) || bothZero);
  assign lt_o = !anyNan && !bothZero && lt_total_o;

endmodule

// File: rtl/cpu_fpu_dispatch.sv
// FPU dispatcher: forwards FADD/FSUB to the external adder, executes min/max,
// sign-injection and compares locally, and returns results on a held handshake.
module cpu_fpu_dispatch
  import cpu_fpu_pkg::*;
(
  input  logic        i_clock,
  input  logic        i_reset,
  input  logic        i_request,
  input  logic [3:0]  i_op,
  input  logic [31:0] i_op1,
  input  logic [31:0] i_op2,
  output logic        o_ready,
  output logic [31:0] o_result,
  output logic        o_add_request,
  output logic [31:0] o_add_op1,
  output logic [31:0] o_add_op2,
  input  logic        i_add_ready,
  input  logic [31:0] i_add_result
);

  state_e      state_q;
  logic [3:0]  op_q;
  logic [31:0] opA_q;
  logic [31:0] opB_q;
  logic [31:0] result_q;
  logic        ready_q;
  logic        addReq_q;
  logic [31:0] addOp1_q;
  logic [31:0] addOp2_q;
  logic [31:0] localResult_d;

  logic nanA;
  logic nanB;
  logic cmpEq;
  logic cmpLt;
  logic cmpLtTotal;

  cpu_fpu_compare u_compare (
    .a_i        (opA_q),
    .b_i        (opB_q),
    .is_nan_a_o (nanA),
    .is_nan_b_o (nanB),
    .eq_o       (cmpEq),
    .lt_o       (cmpLt),
    .lt_total_o (cmpLtTotal)
  );

  always_comb begin
    localResult_d = 32'h0;
    case (op_q)
      FOP_FMIN, FOP_FMAX: begin
        if (nanA && nanB) begin
          localResult_d = QNAN;
        end else if (nanA) begin
          localResult_d = opB_q;
        end else if (nanB) begin
          localResult_d = opA_q;
        end else if (op_q == FOP_FMIN) begin
          localResult_d = cmpLtTotal ? opA_q : opB_q;
        end else begin
          localResult_d = cmpLtTotal ? opB_q : opA_q;
        end
      end
      FOP_FSGNJ:  localResult_d = {opB_q[31], opA_q[30:0]};
      FOP_FSGNJN: localResult_d = {~opB_q[31], opA_q[30:0]};
      FOP_FSGNJX: localResult_d = {opA_q[31] ^ opB_q[31], opA_q[30:0]};
      FOP_FEQ:    localResult_d = {31'd0, cmpEq};
      FOP_FLT:    localResult_d = {31'd0, cmpLt};
      FOP_FLE:    localResult_d = {31'd0, cmpLt | cmpEq};
      default:    localResult_d = 32'h0;
    endcase
  end

  // Adder request is raised one edge after ISSUE entry; the adder must drop
  // its ready (RELEASE) before the CPU sees our result.
  always_ff @(posedge i_clock) begin
    if (i_reset) begin
      state_q  <= ST_IDLE;
      op_q     <= 4'd0;
      opA_q    <= 32'h0;
      opB_q    <= 32'h0;
      result_q <= 32'h0;
      ready_q  <= 1'b0;
      addReq_q <= 1'b0;
      addOp1_q <= 32'h0;
      addOp2_q <= 32'h0;
    end else begin
      case (state_q)
        ST_IDLE: begin
          ready_q <= 1'b0;
          if (i_request) begin
            op_q  <= i_op;
            opA_q <= i_op1;
            opB_q <= i_op2;
            if (isAddOp(i_op)) begin
              addOp1_q <= i_op1;
              addOp2_q <= (i_op == FOP_FSUB) ? {~i_op2[31], i_op2[30:0]} : i_op2;
              state_q  <= ST_ISSUE;
            end else begin
              state_q <= ST_LOCAL;
            end
          end
        end
        ST_LOCAL: begin
          result_q <= localResult_d;
          state_q  <= ST_DONE;
        end
        ST_ISSUE: begin
          if (!addReq_q) begin
            addReq_q <= 1'b1;
          end else if (i_add_ready) begin
            result_q <= i_add_result;
            addReq_q <= 1'b0;
            state_q  <= ST_RELEASE;
          end
        end
        ST_RELEASE: begin
          if (!i_add_ready) begin
            ready_q <= 1'b1;
            state_q <= ST_DONE;
          end
        end
        ST_DONE: begin
          if (!i_request) begin
            ready_q <= 1'b0;
            state_q <= ST_IDLE;
          end else begin
            ready_q <= 1'b1;
          end
        end
        default: begin
          ready_q  <= 1'b0;
          addReq_q <= 1'b0;
          state_q  <= ST_IDLE;
        end
      endcase
    end
  end

  assign o_ready       = ready_q;
  assign o_result      = result_q;
  assign o_add_request = addReq_q;
  assign o_add_op1     = addOp1_q;
  assign o_add_op2     = addOp2_q;

endmodule

// File: tb/tb_cpu_fpu_dispatch.sv
// Scoreboard bench for cpu_fpu_dispatch with a 3-cycle adder model and
// directed vectors carrying hand-computed expected results.
module tb_cpu_fpu_dispatch;
  import cpu_fpu_pkg::*;

  logic        i_clock = 1'b0;
  logic        i_reset;
  logic        i_request;
  logic [3:0]  i_op;
  logic [31:0] i_op1;
  logic [31:0] i_op2;
  logic        o_ready;
  logic [31:0] o_result;
  logic        o_add_request;
  logic [31:0] o_add_op1;
  logic [31:0] o_add_op2;
  logic        i_add_ready;
  logic [31:0] i_add_result;

  int vectorsApplied = 0;
  int miscompares    = 0;

  logic [31:0] expQ[$];
  string       nameQ[$];
  logic [31:0] monExp;
  string       monName;
  logic        readyPrev = 1'b0;

  logic        addStall;
  logic [31:0] addResultValue;
  logic        addReady;
  int          addCnt;

  cpu_fpu_dispatch dut (
    .i_clock       (i_clock),
    .i_reset       (i_reset),
    .i_request     (i_request),
    .i_op          (i_op),
    .i_op1         (i_op1),
    .i_op2         (i_op2),
    .o_ready       (o_ready),
    .o_result      (o_result),
    .o_add_request (o_add_request),
    .o_add_op1     (o_add_op1),
    .o_add_op2     (o_add_op2),
    .i_add_ready   (i_add_ready),
    .i_add_result  (i_add_result)
  );

  always #5 i_clock = ~i_clock;

  assign i_add_ready  = addReady;
  assign i_add_result = addResultValue;

  // Adder model: ready three edges after it sees a request, held until the request drops.
  always @(posedge i_clock) begin
    if (i_reset || !o_add_request) begin
      addCnt   <= 0;
      addReady <= 1'b0;
    end else if (!addStall) begin
      if (addCnt == 2) addReady <= 1'b1;
      else addCnt <= addCnt + 1;
    end
  end

  task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
    vectorsApplied++;
    if (actual !== expected) begin
      miscompares++;
      $display("[TB] FAIL %s: got %h, expected %h", name, actual, expected);
    end
  endtask

  // Monitor: every rising o_ready consumes one scoreboard entry.
  always @(negedge i_clock) begin
    if (i_reset) begin
      readyPrev <= 1'b0;
    end else begin
      if (o_ready && !readyPrev) begin
        if (expQ.size() == 0) begin
          vectorsApplied++;
          miscompares++;
          $display("[TB] FAIL unexpected result: got %h, expected no response", o_result);
        end else begin
          monExp  = expQ.pop_front();
          monName = nameQ.pop_front();
          checkOutput({monName, " result"}, o_result, monExp);
        end
      end
      readyPrev <= o_ready;
    end
  end

  task automatic applyStimulus(input string name, input logic [3:0] op, input logic [31:0] a,
                               input logic [31:0] b, input logic [31:0] expected,
                               input logic [31:0] expAddOp2, input int holdCycles, input bit scramble);
    bit          isAdd;
    bit          sawAddReq;
    bit          stable;
    int          edges;
    logic [31:0] addOp2Seen;
    isAdd      = (op == FOP_FADD) || (op == FOP_FSUB);
    sawAddReq  = 1'b0;
    addOp2Seen = 32'h0;
    @(negedge i_clock);
    i_request = 1'b1;
    i_op      = op;
    i_op1     = a;
    i_op2     = b;
    expQ.push_back(expected);
    nameQ.push_back(name);
    @(posedge i_clock);
    @(negedge i_clock);
    if (scramble) begin
      i_op1 = ~a;
      i_op2 = 32'h12345678;
      i_op  = FOP_FEQ;
    end
    edges = 0;
    while (!o_ready && edges < 60) begin
      if (o_add_request) begin
        sawAddReq  = 1'b1;
        addOp2Seen = o_add_op2;
      end
      @(negedge i_clock);
      edges++;
    end
    if (!o_ready) begin
      vectorsApplied++;
      miscompares++;
      $display("[TB] FAIL %s timeout: o_ready still %b after %0d edges, expected 1", name, o_ready, edges);
      void'(expQ.pop_front());
      void'(nameQ.pop_front());
      i_request = 1'b0;
      @(negedge i_clock);
      return;
    end
    if (isAdd) begin
      checkOutput({name, " add op2"}, addOp2Seen, expAddOp2);
      checkOutput({name, " add request seen"}, {31'd0, sawAddReq}, 32'd1);
      checkOutput({name, " add request dropped before ready"}, {31'd0, o_add_request}, 32'd0);
    end else begin
      checkOutput({name, " latency"}, edges, 32'd2);
    end
    stable = 1'b1;
    repeat (holdCycles) begin
      @(negedge i_clock);
      if (!o_ready || o_result !== expected) stable = 1'b0;
    end
    if (holdCycles > 0) checkOutput({name, " hold stable"}, {31'd0, stable}, 32'd1);
    i_request = 1'b0;
    @(negedge i_clock);
    checkOutput({name, " ready release"}, {31'd0, o_ready}, 32'd0);
  endtask

  initial begin
    i_reset        = 1'b1;
    i_request      = 1'b0;
    i_op           = 4'd0;
    i_op1          = 32'h0;
    i_op2          = 32'h0;
    addStall       = 1'b0;
    addResultValue = 32'h0;
    repeat (2) @(posedge i_clock);
    @(negedge i_clock);
    checkOutput("reset o_ready", {31'd0, o_ready}, 32'd0);
    checkOutput("reset o_result", o_result, 32'h0);
    checkOutput("reset o_add_request", {31'd0, o_add_request}, 32'd0);
    checkOutput("reset o_add_op1", o_add_op1, 32'h0);
    checkOutput("reset o_add_op2", o_add_op2, 32'h0);
    i_reset = 1'b0;

    addResultValue = 32'h40400000;
    applyStimulus("fadd 1+2", FOP_FADD, 32'h3F800000, 32'h40000000, 32'h40400000, 32'h40000000, 0, 1'b0);
    addResultValue = 32'h00000000;
    applyStimulus("fsub 1-1", FOP_FSUB, 32'h3F800000, 32'h3F800000, 32'h00000000, 32'hBF800000, 0, 1'b0);
    applyStimulus("fmin -0,+0", FOP_FMIN, 32'h80000000, 32'h00000000, 32'h80000000, 32'h0, 0, 1'b0);
    applyStimulus("fmax nan,2", FOP_FMAX, 32'h7FC00001, 32'h40000000, 32'h40000000, 32'h0, 0, 1'b0);
    applyStimulus("fmax nan,nan", FOP_FMAX, 32'h7FC00001, 32'hFF800001, 32'h7FC00000, 32'h0, 0, 1'b0);
    applyStimulus("fmax +0,-0", FOP_FMAX, 32'h00000000, 32'h80000000, 32'h00000000, 32'h0, 0, 1'b0);
    applyStimulus("fmin 2,-2", FOP_FMIN, 32'h40000000, 32'hC0000000, 32'hC0000000, 32'h0, 0, 1'b0);
    applyStimulus("fmax -3,-2", FOP_FMAX, 32'hC0400000, 32'hC0000000, 32'hC0000000, 32'h0, 0, 1'b0);
    applyStimulus("flt 1,2", FOP_FLT, 32'h3F800000, 32'h40000000, 32'd1, 32'h0, 0, 1'b0);
    applyStimulus("feq +0,-0", FOP_FEQ, 32'h00000000, 32'h80000000, 32'd1, 32'h0, 0, 1'b0);
    applyStimulus("flt +0,-0", FOP_FLT, 32'h00000000, 32'h80000000, 32'd0, 32'h0, 0, 1'b0);
    applyStimulus("fle nan,1", FOP_FLE, 32'h7FC00000, 32'h3F800000, 32'd0, 32'h0, 0, 1'b0);
    applyStimulus("fle 2,2", FOP_FLE, 32'h40000000, 32'h40000000, 32'd1, 32'h0, 0, 1'b0);
    applyStimulus("fsgnj", FOP_FSGNJ, 32'h3F800000, 32'h80000000, 32'hBF800000, 32'h0, 0, 1'b0);
    applyStimulus("fsgnjn", FOP_FSGNJN, 32'h3F800000, 32'h3F800000, 32'hBF800000, 32'h0, 0, 1'b0);
    applyStimulus("undefined op", 4'd12, 32'h3F800000, 32'h40000000, 32'h00000000, 32'h0, 0, 1'b0);
    applyStimulus("fmin hold+scramble", FOP_FMIN, 32'h40400000, 32'h3F800000, 32'h3F800000, 32'h0, 5, 1'b1);
    applyStimulus("fsgnjx", FOP_FSGNJX, 32'hBF800000, 32'hC0000000, 32'h3F800000, 32'h0, 0, 1'b0);

    // Reset in the middle of an adder transaction that the adder never answers.
    addStall       = 1'b1;
    addResultValue = 32'h40400000;
    @(negedge i_clock);
    i_request = 1'b1;
    i_op      = FOP_FADD;
    i_op1     = 32'h3F800000;
    i_op2     = 32'h40000000;
    repeat (2) @(posedge i_clock);
    @(negedge i_clock);
    checkOutput("rst mid-issue add request raised", {31'd0, o_add_request}, 32'd1);
    i_reset   = 1'b1;
    i_request = 1'b0;
    @(negedge i_clock);
    checkOutput("rst mid-issue o_add_request", {31'd0, o_add_request}, 32'd0);
    checkOutput("rst mid-issue o_ready", {31'd0, o_ready}, 32'd0);
    checkOutput("rst mid-issue o_result", o_result, 32'h0);
    checkOutput("rst mid-issue o_add_op2", o_add_op2, 32'h0);
    i_reset  = 1'b0;
    addStall = 1'b0;
    applyStimulus("fadd after reset", FOP_FADD, 32'h3F800000, 32'h40000000, 32'h40400000, 32'h40000000, 3, 1'b1);

    repeat (3) @(negedge i_clock);
    checkOutput("scoreboard drained", expQ.size(), 32'd0);
    $display("== %0d vectors applied, %0d miscompares ==", vectorsApplied, miscompares);
    $finish;
  end

endmodule
